// File: rtl/dvs_ravens_pkg.sv
// Shared constants for the DVS event path.
package dvs_ravens_pkg;
    localparam int unsigned EVENT_BITS = 16;
endpackage

// File: rtl/dvs_event_fifo.sv
// First-word-fall-through event FIFO with request/grant write access and drop tracking.
// Define DVS_EVENT_FIFO_STATS_EN to build the drop_count / high_water statistics.
module dvs_event_fifo #(
    parameter int unsigned EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_req,
    output logic                       fifo_grant,
    input  logic                       fifo_wr_en,
    input  logic [EVENT_BITS-1:0]      fifo_event,
    output logic [EVENT_BITS-1:0]      event_out,
    output logic                       event_valid,
    input  logic                       event_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic [$clog2(DEPTH):0]     high_water
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {StIdle, StGranted} state_t;

    state_t                state_q, state_d;
    logic [EVENT_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  pop, wr_acc, drop;

    assign count       = count_q;
    assign full        = (count_q == CW'(DEPTH));
    assign event_valid = (count_q != '0);
    assign event_out   = mem[rptr_q];
    assign fifo_grant  = (state_q == StGranted);
    assign overflow    = overflow_q;

    assign pop    = event_valid && event_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still take the write.
    assign wr_acc = fifo_wr_en && fifo_grant && (!full || pop);
    assign drop   = fifo_wr_en && !wr_acc;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (fifo_req && !full) state_d = StGranted;
            StGranted: if (!fifo_req) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_acc) wptr_q <= wptr_q + 1'b1;
            if (pop)    rptr_q <= rptr_q + 1'b1;
            unique case ({wr_acc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wptr_q] <= fifo_event;
    end

`ifdef DVS_EVENT_FIFO_STATS_EN
    logic [15:0]   drop_q;
    logic [CW-1:0] hw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            hw_q   <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (count_q > hw_q) hw_q <= count_q;
        end
    end

    assign drop_count = drop_q;
    assign high_water = hw_q;
`else
    assign drop_count = '0;
    assign high_water = '0;
`endif

endmodule
